// File: rtl/i3c_phy_pkg.sv
// Shared constants and types for the multi-line I3C/I2C PHY front end.
// Line indices follow the bus convention: bit 0 is SCL, bit 1 is SDA.
package i3c_phy_pkg;

  localparam int DefNumLines   = 2;
  localparam int DefSyncStages = 2;
  localparam int DefFiltCntW   = 4;
  localparam int DefStuckCntW  = 16;

  localparam int SclIdx = 0;
  localparam int SdaIdx = 1;

  typedef struct packed {
    logic value;
    logic rise;
    logic fall;
    logic stuck;
  } line_status_t;

  typedef enum logic [1:0] {
    FiltIdle,
    FiltCount,
    FiltAccept
  } filt_action_e;

endpackage

// File: rtl/i3c_phy_line_filter.sv
// One bus line: synchroniser, programmable spike filter, edge pulses and an optional
// stuck-low counter (enabled with macro I3C_PHY_STUCK_DET_EN).
module i3c_phy_line_filter
  import i3c_phy_pkg::*;
#(
  parameter int SyncStages = DefSyncStages,
  parameter int FiltCntW   = DefFiltCntW,
  parameter int StuckCntW  = DefStuckCntW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 line_i,
  input  logic [FiltCntW-1:0]  filt_len_i,
  input  logic [StuckCntW-1:0] stuck_thr_i,
  output line_status_t         status_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic                  q, q_d;
  logic [FiltCntW-1:0]   cnt, cnt_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  stuck;
  filt_action_e          action;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], line_i};
    end
  end

  assign s = sync_q[SyncStages-1];

  // cnt never passes filt_len_i because reaching it forces an accept, so it cannot wrap.
  always_comb begin
    action = FiltIdle;
    q_d    = q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != q) begin
      action = (cnt >= filt_len_i) ? FiltAccept : FiltCount;
    end
    case (action)
      FiltCount: cnt_d = cnt + 1'b1;
      FiltAccept: begin
        q_d    = s;
        rise_d = s;
        fall_d = ~s;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q      <= 1'b1;
      cnt    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q      <= q_d;
      cnt    <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

`ifdef I3C_PHY_STUCK_DET_EN
  logic [StuckCntW-1:0] stuck_cnt;

  // Tracks q_d so the count equals the number of low cycles already visible on ctrl_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stuck_cnt <= '0;
    end else if (q_d) begin
      stuck_cnt <= '0;
    end else if (stuck_cnt != '1) begin
      stuck_cnt <= stuck_cnt + 1'b1;
    end
  end

  assign stuck = (stuck_thr_i != '0) && (stuck_cnt >= stuck_thr_i);
`else
  logic unused_stuck_thr;

  assign unused_stuck_thr = ^stuck_thr_i;
  assign stuck            = 1'b0;
`endif

  assign status_o.value = q;
  assign status_o.rise  = rise_q;
  assign status_o.fall  = fall_q;
  assign status_o.stuck = stuck;

endmodule

// File: rtl/i3c_phy_multi.sv
// N-line I3C/I2C PHY front end: filtered input path per line plus registered drive path.
// Stuck-low detection is built only when I3C_PHY_STUCK_DET_EN is defined.
module i3c_phy_multi
  import i3c_phy_pkg::*;
#(
  parameter int NumLines   = DefNumLines,
  parameter int SyncStages = DefSyncStages,
  parameter int FiltCntW   = DefFiltCntW,
  parameter int StuckCntW  = DefStuckCntW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumLines-1:0]  bus_i,
  output logic [NumLines-1:0]  bus_o,
  input  logic [NumLines-1:0]  sel_od_pp_i,
  output logic [NumLines-1:0]  sel_od_pp_o,
  input  logic [NumLines-1:0]  ctrl_i,
  output logic [NumLines-1:0]  ctrl_o,
  output logic [NumLines-1:0]  rise_o,
  output logic [NumLines-1:0]  fall_o,
  input  logic [FiltCntW-1:0]  filt_len_i,
  input  logic [StuckCntW-1:0] stuck_thr_i,
  output logic [NumLines-1:0]  stuck_o
);

  line_status_t status [NumLines];

  for (genvar i = 0; i < NumLines; i++) begin : g_line
    i3c_phy_line_filter #(
      .SyncStages(SyncStages),
      .FiltCntW  (FiltCntW),
      .StuckCntW (StuckCntW)
    ) u_line (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .line_i     (bus_i[i]),
      .filt_len_i (filt_len_i),
      .stuck_thr_i(stuck_thr_i),
      .status_o   (status[i])
    );

    assign ctrl_o[i]  = status[i].value;
    assign rise_o[i]  = status[i].rise;
    assign fall_o[i]  = status[i].fall;
    assign stuck_o[i] = status[i].stuck;
  end

  // Drive path is a plain register stage, independent of what the pads read back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_o       <= '1;
      sel_od_pp_o <= '0;
    end else begin
      bus_o       <= ctrl_i;
      sel_od_pp_o <= sel_od_pp_i;
    end
  end

endmodule

// File: tb/tb_i3c_phy_multi.sv
// Self-checking bench for i3c_phy_multi: directed stimulus queues expected edge events,
// a negedge monitor pops and compares them whenever rise_o/fall_o fire.
module tb_i3c_phy_multi;
  import i3c_phy_pkg::*;

  localparam int NumLines   = 2;
  localparam int SyncStages = 2;
  localparam int FiltCntW   = 4;
  localparam int StuckCntW  = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NumLines-1:0]  bus_i;
  logic [NumLines-1:0]  bus_o;
  logic [NumLines-1:0]  sel_od_pp_i;
  logic [NumLines-1:0]  sel_od_pp_o;
  logic [NumLines-1:0]  ctrl_i;
  logic [NumLines-1:0]  ctrl_o;
  logic [NumLines-1:0]  rise_o;
  logic [NumLines-1:0]  fall_o;
  logic [FiltCntW-1:0]  filt_len_i;
  logic [StuckCntW-1:0] stuck_thr_i;
  logic [NumLines-1:0]  stuck_o;

  typedef struct {
    int line;
    bit rise;
    int cycle;
  } edge_t;

  edge_t exp_q[$];
  edge_t mon_e;
  int    cycle        = 0;
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    k;

`ifdef I3C_PHY_STUCK_DET_EN
  localparam logic StuckExp = 1'b1;
`else
  localparam logic StuckExp = 1'b0;
`endif

  i3c_phy_multi #(
    .NumLines  (NumLines),
    .SyncStages(SyncStages),
    .FiltCntW  (FiltCntW),
    .StuckCntW (StuckCntW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus_i      (bus_i),
    .bus_o      (bus_o),
    .sel_od_pp_i(sel_od_pp_i),
    .sel_od_pp_o(sel_od_pp_o),
    .ctrl_i     (ctrl_i),
    .ctrl_o     (ctrl_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .filt_len_i (filt_len_i),
    .stuck_thr_i(stuck_thr_i),
    .stuck_o    (stuck_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic waitUntilCycle(input int target);
    while (cycle < target) @(negedge clk_i);
  endtask

  // The filtered edge should appear SyncStages + filt_len_i + 1 cycles after the drive cycle.
  task automatic applyStimulus(input int line, input logic val, input bit exp_edge);
    bus_i[line] = val;
    if (exp_edge) begin
      exp_q.push_back('{line: line, rise: val,
                        cycle: cycle + SyncStages + int'(filt_len_i) + 1});
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NumLines; i++) begin
        if (rise_o[i] || fall_o[i]) begin
          checkOutput($sformatf("edge_exclusive_l%0d", i), 32'(rise_o[i] & fall_o[i]), 32'd0);
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_edge line %0d at cycle %0d: rise=%0b fall=%0b, expected none",
                     i, cycle, rise_o[i], fall_o[i]);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("edge_line", 32'(i), 32'(mon_e.line));
            checkOutput("edge_dir_rise", 32'(rise_o[i]), 32'(mon_e.rise));
            checkOutput("edge_cycle", 32'(cycle), 32'(mon_e.cycle));
            checkOutput("edge_value", 32'(ctrl_o[i]), 32'(mon_e.rise));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    bus_i       = '0;
    ctrl_i      = '0;
    sel_od_pp_i = '0;
    filt_len_i  = 4'd3;
    stuck_thr_i = '0;

    // Reset with pads low: sync flops hold 1, so ctrl_o must stay high.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_ctrl_o", 32'(ctrl_o), 32'h3);
    checkOutput("reset_bus_o", 32'(bus_o), 32'h3);
    checkOutput("reset_sel_od_pp_o", 32'(sel_od_pp_o), 32'h0);
    checkOutput("reset_rise_o", 32'(rise_o), 32'h0);
    checkOutput("reset_fall_o", 32'(fall_o), 32'h0);
    checkOutput("reset_stuck_o", 32'(stuck_o), 32'h0);
    bus_i = '1;
    step(1);
    rst_i = 1'b0;

    // Output path.
    ctrl_i      = 2'b01;
    sel_od_pp_i = 2'b10;
    checkOutput("outpath_hold_bus_o", 32'(bus_o), 32'h3);
    step(1);
    checkOutput("outpath_bus_o", 32'(bus_o), 32'h1);
    checkOutput("outpath_sel_od_pp_o", 32'(sel_od_pp_o), 32'h2);
    ctrl_i      = 2'b10;
    sel_od_pp_i = 2'b01;
    step(1);
    checkOutput("outpath2_bus_o", 32'(bus_o), 32'h2);
    checkOutput("outpath2_sel_od_pp_o", 32'(sel_od_pp_o), 32'h1);

    // Glitch reject: 3-cycle low on SDA dropped, 4-cycle low accepted.
    step(2);
    applyStimulus(SdaIdx, 1'b0, 1'b0);
    step(3);
    applyStimulus(SdaIdx, 1'b1, 1'b0);
    step(12);
    checkOutput("glitch_ctrl_o", 32'(ctrl_o), 32'h3);
    k = cycle;
    applyStimulus(SdaIdx, 1'b0, 1'b1);
    step(4);
    applyStimulus(SdaIdx, 1'b1, 1'b1);
    waitUntilCycle(k + 5);
    checkOutput("filter_pre_accept_sda", 32'(ctrl_o[SdaIdx]), 32'h1);
    waitUntilCycle(k + 6);
    checkOutput("filter_accept_sda", 32'(ctrl_o[SdaIdx]), 32'h0);
    step(12);

    // Bypass: SCL toggling every 2 cycles with no filtering.
    filt_len_i = 4'd0;
    step(2);
    for (int t = 0; t < 6; t++) begin
      applyStimulus(SclIdx, logic'(t % 2), 1'b1);
      step(2);
    end
    step(6);
    checkOutput("bypass_end_ctrl_o", 32'(ctrl_o), 32'h3);

    // Mid-filter reset: cnt is 2 when reset hits, the count must restart from 0.
    filt_len_i = 4'd3;
    step(2);
    k = cycle;
    applyStimulus(SdaIdx, 1'b0, 1'b0);
    step(4);
    rst_i = 1'b1;
    step(1);
    checkOutput("midreset_ctrl_o", 32'(ctrl_o), 32'h3);
    checkOutput("midreset_fall_o", 32'(fall_o), 32'h0);
    rst_i = 1'b0;
    applyStimulus(SdaIdx, 1'b0, 1'b1);
    waitUntilCycle(k + 10);
    checkOutput("midreset_restart_hold", 32'(ctrl_o[SdaIdx]), 32'h1);
    step(4);
    applyStimulus(SdaIdx, 1'b1, 1'b1);
    step(12);

    // Stuck-low on SCL with threshold 100.
    filt_len_i  = 4'd0;
    stuck_thr_i = 16'd100;
    step(2);
    k = cycle;
    applyStimulus(SclIdx, 1'b0, 1'b1);
    waitUntilCycle(k + 101);
    checkOutput("stuck_99_low", 32'(stuck_o[SclIdx]), 32'h0);
    waitUntilCycle(k + 102);
    checkOutput("stuck_100_low", 32'(stuck_o[SclIdx]), 32'(StuckExp));
    checkOutput("stuck_other_line", 32'(stuck_o[SdaIdx]), 32'h0);
    waitUntilCycle(k + 150);
    applyStimulus(SclIdx, 1'b1, 1'b1);
    waitUntilCycle(k + 152);
    checkOutput("stuck_before_release", 32'(stuck_o[SclIdx]), 32'(StuckExp));
    waitUntilCycle(k + 153);
    checkOutput("stuck_after_release", 32'(stuck_o[SclIdx]), 32'h0);
    stuck_thr_i = '0;

    step(10);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
